led_activity_blinker: RTL and testbench

//  Parametrised multi-channel LED driver; successor to the ad-hoc LED counters in the top level.

---
 rtl/led_activity_blinker.sv | 85 ++++++++
 tb/tb_led_activity_blinker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_activity_blinker.sv
// Multi-channel LED driver: per-channel off/on/blink/event-stretch modes,
// shared free-running counter for blink phase and a wrap heartbeat pulse.
module led_activity_blinker #(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DIV_BIT     = 26,
  parameter int unsigned STRETCH_W   = 24,
  parameter int unsigned STRETCH_LEN = 5_000_000,
  parameter int unsigned ALT_PHASE   = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [N_CH-1:0]     evt,
  output logic [N_CH-1:0]     led,
  output logic                heartbeat
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_EVENT = 2'b11
  } mode_e;

  localparam logic [STRETCH_W-1:0] LP_LEN = STRETCH_W'(STRETCH_LEN);

  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_hb_next;
  logic [N_CH-1:0]      r_s1, r_s2, r_s3;
  logic [N_CH-1:0]      w_rise;
  logic [STRETCH_W-1:0] r_st      [N_CH];
  logic [STRETCH_W-1:0] w_st_next [N_CH];
  logic [N_CH-1:0]      w_led_next;
  mode_e                w_mode;

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_hb_next  = (w_cnt_next == '0);
  assign w_rise     = r_s2 & ~r_s3;

  // LED is computed from next-state values so it lines up with the edge
  // where the counter / stretch register takes its new value.
  always_comb begin
    w_led_next = '0;
    w_mode     = MODE_OFF;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_st_next[i] = r_st[i];
      if (w_rise[i])
        w_st_next[i] = LP_LEN;
      else if (r_st[i] != '0)
        w_st_next[i] = r_st[i] - 1'b1;

      w_mode = mode_e'(mode[2*i +: 2]);
      case (w_mode)
        MODE_OFF:   w_led_next[i] = 1'b0;
        MODE_ON:    w_led_next[i] = 1'b1;
        MODE_BLINK: w_led_next[i] = w_cnt_next[DIV_BIT] ^ ((ALT_PHASE != 0) & i[0]);
        MODE_EVENT: w_led_next[i] = (w_st_next[i] != '0);
        default:    w_led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt     <= '0;
      heartbeat <= 1'b0;
      led       <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_st      <= '{default: '0};
    end else begin
      r_cnt     <= w_cnt_next;
      heartbeat <= w_hb_next;
      led       <= w_led_next;
      r_s1      <= evt;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_st      <= w_st_next;
    end
  end

endmodule

// File: tb/tb_led_activity_blinker.sv
// Directed bench for led_activity_blinker with a short counter, fast blink
// and a 5-cycle stretch so every behaviour fits in a few dozen clocks.
module tb_led_activity_blinker;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] mode  = '0;
  logic [2:0] evt   = '0;
  logic [2:0] led;
  logic       hb;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  led_activity_blinker #(
    .N_CH(3), .CNT_W(4), .DIV_BIT(3), .STRETCH_W(4), .STRETCH_LEN(5), .ALT_PHASE(1)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .evt(evt),
    .led(led), .heartbeat(hb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, then release mid-cycle so the next posedge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    evt   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode  = 6'b010101;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== 3'b000 || hb !== 1'b0)
        $display("FAIL reset_hold k=%0d led=%b hb=%b expected led=000 hb=0", k, led, hb);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (led !== 3'b111) $display("FAIL reset_release led=%b expected 111", led);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic b;
    mode = 6'b101010;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      tick();
      b = ((e % 16) >= 8);
      n_checks++;
      if (led !== {b, ~b, b})
        $display("FAIL blink edge=%0d led=%b expected %b", e, led, {b, ~b, b});
      else n_pass++;
    end
  endtask

  task automatic test_heartbeat();
    mode = 6'b000000;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      tick();
      n_checks++;
      if (hb !== (e % 16 == 0))
        $display("FAIL heartbeat edge=%0d hb=%b expected %b", e, hb, (e % 16 == 0));
      else n_pass++;
    end
  endtask

  // ch0 event mode, ch1 forced on, ch2 off; evt[0] pulses high for the
  // cycle before each listed edge.
  task automatic run_event(input string name, input int p1, input int p2,
                           input int lo, input int hi, input int last);
    logic b;
    mode = 6'b000111;
    do_reset();
    for (int e = 1; e <= last; e++) begin
      evt[0] = (e == p1) || (e == p2);
      tick();
      b = (e >= lo) && (e <= hi);
      n_checks++;
      if (led !== {1'b0, 1'b1, b})
        $display("FAIL %s edge=%0d led=%b expected %b", name, e, led, {1'b0, 1'b1, b});
      else n_pass++;
    end
    evt = '0;
  endtask

  task automatic test_event();
    run_event("event_single", 10, -1, 12, 16, 22);
  endtask

  task automatic test_retrigger();
    run_event("event_retrigger", 10, 13, 12, 19, 24);
  endtask

  task automatic test_reload_at_one();
    run_event("event_reload_st1", 10, 15, 12, 21, 26);
  endtask

  task automatic test_mode_change();
    logic b;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      mode   = (e == 13 || e == 14) ? 6'b000100 : 6'b000111;
      evt[0] = (e == 10);
      tick();
      b = (e >= 12) && (e <= 16) && !(e == 13 || e == 14);
      n_checks++;
      if (led !== {1'b0, 1'b1, b})
        $display("FAIL mode_change edge=%0d led=%b expected %b", e, led, {1'b0, 1'b1, b});
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    mode = 6'b000011;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      evt[0] = (e == 10);
      tick();
    end
    n_checks++;
    if (led !== 3'b001) $display("FAIL async_pre led=%b expected 001", led);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 3'b000 || hb !== 1'b0)
      $display("FAIL async_immediate led=%b hb=%b expected led=000 hb=0", led, hb);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (led !== 3'b000) $display("FAIL async_after edge=%0d led=%b expected 000", e, led);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_heartbeat();
    test_event();
    test_retrigger();
    test_reload_at_one();
    test_mode_change();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
